// File: rtl/esm.sv
// Register-field scrambler between fetch and decode. It renames the rd, rs1 and rs2
// fields of RV32 instructions through a fixed rotation of the pool x1..x(bs-1).
module esm #(
  parameter int Instruction_word_size = 32,
  parameter int bs                    = 16,
  parameter int KEY                   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [Instruction_word_size-1:0] Instr_in,
  input  logic                             RegWrite,
  input  logic                             ALUSrc,
  output logic [Instruction_word_size-1:0] Instr_out
);

  if (Instruction_word_size != 32) begin : g_bad_width
    $error("esm: Instruction_word_size must be 32");
  end
  if (bs < 3 || bs > 32) begin : g_bad_bs
    $error("esm: bs must be in 3..32");
  end
  if (KEY < 0 || KEY > bs - 2) begin : g_bad_key
    $error("esm: KEY must be in 0..bs-2");
  end

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // x0 and registers outside the pool map to themselves, so x0 is never disturbed.
  function automatic logic [4:0] map_const(input int r);
    if (r == 0 || r >= bs) begin
      return 5'(r);
    end
    return 5'(((r - 1 + KEY) % (bs - 1)) + 1);
  endfunction

  logic [4:0] map_lut [32];

  for (genvar i = 0; i < 32; i++) begin : g_lut
    assign map_lut[i] = map_const(i);
  end

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rd_en;
  logic       rs1_en;
  logic       rs2_en;
  logic [Instruction_word_size-1:0] instr_next;

  assign opcode = Instr_in[6:0];
  assign rd     = Instr_in[11:7];
  assign rs1    = Instr_in[19:15];
  assign rs2    = Instr_in[24:20];

  always_comb begin
    rd_en  = 1'b0;
    rs1_en = 1'b0;
    rs2_en = 1'b0;
    case (opcode)
      OP_R: begin
        rd_en  = RegWrite;
        rs1_en = 1'b1;
        rs2_en = !ALUSrc;
      end
      OP_I, OP_LD, OP_JALR: begin
        rd_en  = RegWrite;
        rs1_en = 1'b1;
      end
      OP_ST: begin
        rs1_en = 1'b1;
        rs2_en = 1'b1;
      end
      OP_BR: begin
        rs1_en = 1'b1;
        rs2_en = !ALUSrc;
      end
      OP_JAL, OP_LUI, OP_AUIPC: begin
        rd_en = RegWrite;
      end
      default: begin
        rd_en  = 1'b0;
        rs1_en = 1'b0;
        rs2_en = 1'b0;
      end
    endcase
  end

  // Fields that are not register indices for this opcode may carry immediate bits.
  always_comb begin
    instr_next = Instr_in;
    if (rd_en) begin
      instr_next[11:7] = map_lut[rd];
    end
    if (rs1_en) begin
      instr_next[19:15] = map_lut[rs1];
    end
    if (rs2_en) begin
      instr_next[24:20] = map_lut[rs2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Instr_out <= '0;
    end else begin
      Instr_out <= instr_next;
    end
  end

endmodule

// File: tb/tb_esm.sv
// Scoreboard bench for esm: stimulus pushes hand-computed expectations,
// a monitor pops one per accepted clock edge and compares.
module tb_esm;

  logic        clk;
  logic        rst;
  logic [31:0] Instr_in;
  logic        RegWrite;
  logic        ALUSrc;
  logic [31:0] Instr_out;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] ins;
    logic        rw;
    logic        as;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          idx;
  } sb_t;

  sb_t exp_q [$];

  localparam int NVEC = 19;
  vec_t vecs [NVEC] = '{
    '{32'h00C58533, 1'b1, 1'b0, 32'h00F706B3},
    '{32'h00450613, 1'b1, 1'b1, 32'h00468793},
    '{32'h00000013, 1'b0, 1'b1, 32'h00000013},
    '{32'h00058533, 1'b1, 1'b0, 32'h000706B3},
    '{32'h00450013, 1'b0, 1'b1, 32'h00468013},
    '{32'h01FA8A33, 1'b1, 1'b0, 32'h01FA8A33},
    '{32'h00C52023, 1'b0, 1'b1, 32'h00F6A023},
    '{32'h000000EF, 1'b1, 1'b0, 32'h0000026F},
    '{32'h000000EF, 1'b0, 1'b0, 32'h000000EF},
    '{32'h123452B7, 1'b1, 1'b0, 32'h12345437},
    '{32'h002081E3, 1'b1, 1'b0, 32'h005201E3},
    '{32'h002081E3, 1'b0, 1'b1, 32'h002201E3},
    '{32'h00C5857F, 1'b1, 1'b0, 32'h00C5857F},
    '{32'h00D707B3, 1'b1, 1'b0, 32'h001101B3},
    '{32'h01080833, 1'b1, 1'b0, 32'h01080833},
    '{32'h005780E7, 1'b1, 1'b0, 32'h00518267},
    '{32'h00001117, 1'b1, 1'b1, 32'h00001297},
    '{32'h00422183, 1'b1, 1'b0, 32'h0043A303},
    '{32'h00450613, 1'b1, 1'b0, 32'h00468793}
  };

  esm dut (
    .clk       (clk),
    .rst       (rst),
    .Instr_in  (Instr_in),
    .RegWrite  (RegWrite),
    .ALUSrc    (ALUSrc),
    .Instr_out (Instr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Monitor: every edge with reset released and a pending entry produces one output.
  always @(posedge clk) begin
    if (rst === 1'b1 && exp_q.size() > 0) begin
      sb_t e;
      e = exp_q.pop_front();
      #1;
      check("vec", e.idx, Instr_out, e.exp);
    end
  end

  task automatic drive(input int i);
    sb_t e;
    Instr_in = vecs[i].ins;
    RegWrite = vecs[i].rw;
    ALUSrc   = vecs[i].as;
    e.exp    = vecs[i].exp;
    e.idx    = i;
    exp_q.push_back(e);
  endtask

  task automatic send(input int i);
    @(negedge clk);
    drive(i);
  endtask

  task automatic raw_send(input logic [31:0] ins, input logic [31:0] exp);
    sb_t e;
    @(negedge clk);
    Instr_in = ins;
    RegWrite = 1'b1;
    ALUSrc   = 1'b0;
    e.exp    = exp;
    e.idx    = 99;
    exp_q.push_back(e);
  endtask

  // One-cycle reset pulse; vector i is presented at release and must emerge one edge later.
  task automatic pulse_reset(input int i);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_pulse_immediate", i, Instr_out, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("reset_pulse_hold", i, Instr_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(i);
  endtask

  initial begin
    rst      = 1'b0;
    Instr_in = 32'hFFFFFFFF;
    RegWrite = 1'b1;
    ALUSrc   = 1'b0;
    #1;
    check("reset_initial", 0, Instr_out, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 0, Instr_out, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    raw_send(32'hFFFFFFFF, 32'hFFFFFFFF);

    // Assert reset between edges: output must clear without a clock.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("reset_async", 0, Instr_out, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      send(i);
    end
    for (int i = 0; i < 3; i++) begin
      send(i);
    end
    pulse_reset(6);
    send(13);
    send(10);

    @(negedge clk);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d outputs still pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/esm.md
Name: esm

Overview:
- Register-field scrambler placed between instruction fetch and decode.
- Rewrites the rd, rs1 and rs2 fields of each RV32 instruction through a fixed permutation of a register pool, then registers the result.
- Downstream decode and the register file see a consistently renamed register space.
- RegWrite and ALUSrc, supplied by the main decoder, qualify which fields hold register indices.

Parameters:
- Instruction_word_size, 32, instruction width; only 32 is supported, and elaboration must fail for any other value.
- bs, 16, pool bound; registers x1..x(bs-1) are permuted. Legal range 3..32.
- KEY, 3, rotation amount inside the pool. Legal range 0..bs-2; KEY=0 gives identity.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- Instr_in, input, Instruction_word_size, incoming instruction, sampled every cycle.
- RegWrite, input, 1, 1 = instruction writes rd.
- ALUSrc, input, 1, 1 = second operand is an immediate, so bits 24:20 are not rs2.
- Instr_out, output, Instruction_word_size, remapped instruction, registered.

Behaviour:
- Reset: rst=0 asynchronously forces Instr_out=32'h0. On release, normal operation starts at the next rising clk.
- Latency: exactly 1 cycle. Instr_out after rising edge N reflects Instr_in, RegWrite and ALUSrc sampled at edge N. There is no handshake and no stall; every cycle is accepted.
- Field positions: opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20]. All other bits pass unchanged.
- Map function M(r):
  - r = 0 or r >= bs: M(r) = r.
  - 1 <= r <= bs-1: M(r) = ((r-1+KEY) mod (bs-1)) + 1.
  - Defaults: x1..x12 map to r+3; x13→x1, x14→x2, x15→x3; x16..x31 unchanged.
- Opcode classes: R = 0110011, I = 0010011, LD = 0000011, ST = 0100011, BR = 1100011, JALR = 1100111, JAL = 1101111, LUI = 0110111, AUIPC = 0010111.
- rd is remapped only when RegWrite=1 and the opcode is R, I, LD, JALR, JAL, LUI or AUIPC. Otherwise bits 11:7 pass unchanged; they may be immediate bits.
- rs1 is remapped only when the opcode is R, I, LD, ST, BR or JALR.
- rs2 is remapped when the opcode is ST, or when ALUSrc=0 and the opcode is R or BR.
- Unknown opcodes pass through unchanged.
- x0 is never altered in any field, so writes to x0 stay discarded and reads of x0 stay zero.
- The permutation is a bijection on x1..x(bs-1). Remapping is purely combinational on the current inputs; the only state is the Instr_out register.
- Reset asserted mid-stream: output clears immediately. The first post-reset output is the instruction sampled at the first edge after release.
- The mapping is combinational before the output register. It is implementable as a 32-entry constant lookup generated from the parameters, or as modular arithmetic.

Test Plan:
- Reset: rst=0 with Instr_in=32'hFFFFFFFF -> Instr_out=0 immediately, without waiting for a clock edge; it stays 0 until release.
- R-type ADD: Instr_in=32'h00C58533 (ADD x10,x11,x12), RegWrite=1, ALUSrc=0 -> next cycle Instr_out=32'h00F706B3 (x13,x14,x15).
- I-type ADDI: Instr_in=32'h00450613, RegWrite=1, ALUSrc=1 -> 32'h00468793. The immediate is untouched; rd 12→15, rs1 10→13.
- NOP and x0 cases:
  - 32'h00000013 with RegWrite=0 -> 32'h00000013.
  - 32'h00058533 with RegWrite=1, ALUSrc=0 -> 32'h000706B3 (rs2=x0 kept).
  - 32'h00450013 with RegWrite=0, ALUSrc=1 -> 32'h00468013.
- Out-of-pool and store:
  - ADD x20,x21,x31 (32'h01FA8A33) -> unchanged.
  - SW x12,0(x10), i.e. 32'h00C52023, with RegWrite=0, ALUSrc=1 -> 32'h00F6A023; rs2 is remapped despite ALUSrc=1.
- Back-to-back: the above instructions on consecutive cycles -> each output appears exactly 1 cycle later in order. Then pulse rst low for one cycle mid-stream -> Instr_out=0 at once, and valid outputs resume 1 cycle after release.
